// File: rtl/pipeline_stall_controller.sv
// Pipeline enable/flush sequencer for the 5-stage core: merges load-use stalls,
// branch flushes, MDU multi-cycle ops and data-memory wait into one control set.
module pipeline_stall_controller #(
  parameter int MDU_MAX_CYCLES = 34,
  parameter int CNT_W          = 6,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_use_hz,
  input  logic                   branch_taken,
  input  logic                   mdu_start,
  input  logic                   mdu_done,
  input  logic                   dmem_wait,
  output logic                   PC_E,
  output logic                   IF_ID_E,
  output logic                   ID_EX_E,
  output logic                   EX_MEM_E,
  output logic                   MEM_WB_E,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_flush,
  output logic                   EX_MEM_bubble,
  output logic                   mdu_err,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   ctrl_state
);

  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] mdu_cnt, mdu_cnt_nxt;
  logic             mdu_err_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      mdu_cnt <= '0;
      mdu_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
      mdu_err <= mdu_err_nxt;
    end
  end

  // A memory wait freezes everything, including the MDU timeout count.
  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    mdu_err_nxt = mdu_err;
    if (!dmem_wait) begin
      case (state)
        RUN: begin
          if (!branch_taken && mdu_start && !mdu_done) begin
            state_nxt   = MDU_BUSY;
            mdu_cnt_nxt = CNT_W'(1);
          end
        end
        MDU_BUSY: begin
          if (mdu_done) begin
            state_nxt   = RUN;
            mdu_cnt_nxt = '0;
          end else if (mdu_cnt == CNT_W'(MDU_MAX_CYCLES)) begin
            state_nxt   = RUN;
            mdu_cnt_nxt = '0;
            mdu_err_nxt = 1'b1;
          end else begin
            mdu_cnt_nxt = mdu_cnt + CNT_W'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    PC_E          = 1'b1;
    IF_ID_E       = 1'b1;
    ID_EX_E       = 1'b1;
    EX_MEM_E      = 1'b1;
    MEM_WB_E      = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    EX_MEM_bubble = 1'b0;
    if (reset) begin
      IF_ID_flush   = 1'b1;
      ID_EX_flush   = 1'b1;
      EX_MEM_bubble = 1'b1;
    end else if (dmem_wait) begin
      PC_E     = 1'b0;
      IF_ID_E  = 1'b0;
      ID_EX_E  = 1'b0;
      EX_MEM_E = 1'b0;
      MEM_WB_E = 1'b0;
    end else if (state == MDU_BUSY) begin
      if (!mdu_done) begin
        PC_E          = 1'b0;
        IF_ID_E       = 1'b0;
        ID_EX_E       = 1'b0;
        EX_MEM_bubble = 1'b1;
      end
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (mdu_start) begin
      // Same-cycle done means a single-cycle op: nothing to freeze.
      if (!mdu_done) begin
        PC_E          = 1'b0;
        IF_ID_E       = 1'b0;
        ID_EX_E       = 1'b0;
        EX_MEM_bubble = 1'b1;
      end
    end else if (load_use_hz) begin
      PC_E        = 1'b0;
      IF_ID_E     = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (!PC_E && (stall_cnt != {STALL_CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

  assign ctrl_state = (state == MDU_BUSY);

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed vector table, hand sequences for
// MDU timeout / memory wait / reset corners, then random traffic against a model.
module tb_pipeline_stall_controller;
  localparam int MAXC = 34;
  localparam int SCW  = 8;
  localparam int SMAX = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic reset, load_use_hz, branch_taken, mdu_start, mdu_done, dmem_wait;
  logic PC_E, IF_ID_E, ID_EX_E, EX_MEM_E, MEM_WB_E;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_bubble, mdu_err, ctrl_state;
  logic [SCW-1:0] stall_cnt;

  pipeline_stall_controller #(.MDU_MAX_CYCLES(MAXC), .CNT_W(6), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .reset(reset), .load_use_hz(load_use_hz), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .dmem_wait(dmem_wait),
    .PC_E(PC_E), .IF_ID_E(IF_ID_E), .ID_EX_E(ID_EX_E), .EX_MEM_E(EX_MEM_E),
    .MEM_WB_E(MEM_WB_E), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_bubble(EX_MEM_bubble), .mdu_err(mdu_err), .stall_cnt(stall_cnt),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: is an MDU op outstanding, how many busy cycles it has used, error, stalls.
  bit m_busy, m_err;
  int m_used, m_stall;
  logic [7:0] m_out;  // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB enables, IF_ID_flush, ID_EX_flush, bubble}

  localparam logic [7:0] O_RESET  = 8'b11111_111;
  localparam logic [7:0] O_RUN    = 8'b11111_000;
  localparam logic [7:0] O_HALT   = 8'b00000_000;
  localparam logic [7:0] O_MDU    = 8'b00011_001;
  localparam logic [7:0] O_BRANCH = 8'b11111_110;
  localparam logic [7:0] O_LDUSE  = 8'b00111_010;

  function automatic logic [7:0] dut_out();
    return {PC_E, IF_ID_E, ID_EX_E, EX_MEM_E, MEM_WB_E, IF_ID_flush, ID_EX_flush, EX_MEM_bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_out(input logic r, lu, br, ms, md, dw);
    if (r) return O_RESET;
    if (dw) return O_HALT;
    if (m_busy) return md ? O_RUN : O_MDU;
    if (br) return O_BRANCH;
    if (ms) return md ? O_RUN : O_MDU;
    if (lu) return O_LDUSE;
    return O_RUN;
  endfunction

  task automatic model_step(input logic r, lu, br, ms, md, dw);
    if (r) begin
      m_busy = 0; m_err = 0; m_used = 0; m_stall = 0;
      return;
    end
    if (!m_out[7] && m_stall < SMAX) m_stall++;
    if (dw) return;
    if (m_busy) begin
      if (md) m_busy = 0;
      else if (m_used == MAXC) begin m_busy = 0; m_err = 1; end
      else m_used++;
    end else if (!br && ms && !md) begin
      m_busy = 1; m_used = 1;
    end
  endtask

  task automatic drive(input logic r, lu, br, ms, md, dw);
    reset = r; load_use_hz = lu; branch_taken = br; mdu_start = ms; mdu_done = md; dmem_wait = dw;
  endtask

  task automatic check_model();
    m_out = model_out(reset, load_use_hz, branch_taken, mdu_start, mdu_done, dmem_wait);
    chk("model_ctrl", 32'(dut_out()), 32'(m_out));
    chk("model_regs", {22'd0, ctrl_state, mdu_err, stall_cnt}, {22'd0, m_busy, m_err, 8'(m_stall)});
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step(reset, load_use_hz, branch_taken, mdu_start, mdu_done, dmem_wait);
    #1;
  endtask

  task automatic cycle(input logic r, lu, br, ms, md, dw);
    drive(r, lu, br, ms, md, dw);
    @(negedge clk);
    check_model();
    finish_cycle();
  endtask

  typedef struct {
    logic r, lu, br, ms, md, dw;
    logic [7:0] out;
    logic st, err;
    int sc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1,0,0,0,0,0, O_RESET,  0,0,0};
    tbl[1]  = '{1,0,0,0,0,0, O_RESET,  0,0,0};
    tbl[2]  = '{0,0,0,0,0,0, O_RUN,    0,0,0};
    tbl[3]  = '{0,1,0,0,0,0, O_LDUSE,  0,0,0};
    tbl[4]  = '{0,0,0,0,0,0, O_RUN,    0,0,1};
    tbl[5]  = '{0,1,1,0,0,0, O_BRANCH, 0,0,1};
    tbl[6]  = '{0,0,0,0,0,0, O_RUN,    0,0,1};
    tbl[7]  = '{0,0,0,1,0,0, O_MDU,    0,0,1};
    tbl[8]  = '{0,1,1,1,0,0, O_MDU,    1,0,2};
    tbl[9]  = '{0,0,0,0,0,0, O_MDU,    1,0,3};
    tbl[10] = '{0,0,0,0,0,0, O_MDU,    1,0,4};
    tbl[11] = '{0,0,0,0,1,0, O_RUN,    1,0,5};
    tbl[12] = '{0,0,0,0,0,0, O_RUN,    0,0,5};
    tbl[13] = '{0,0,0,1,1,0, O_RUN,    0,0,5};
    tbl[14] = '{0,0,0,0,0,0, O_RUN,    0,0,5};
    tbl[15] = '{0,1,1,1,0,1, O_HALT,   0,0,5};
    tbl[16] = '{0,0,0,0,0,0, O_RUN,    0,0,6};

    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_step(1, 0, 0, 0, 0, 0);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].lu, tbl[i].br, tbl[i].ms, tbl[i].md, tbl[i].dw);
      @(negedge clk);
      check_model();
      chk($sformatf("vec%0d_ctrl", i), 32'(dut_out()), 32'(tbl[i].out));
      chk($sformatf("vec%0d_regs", i), {22'd0, ctrl_state, mdu_err, stall_cnt},
          {22'd0, tbl[i].st, tbl[i].err, 8'(tbl[i].sc)});
      finish_cycle();
    end

    // MDU timeout: 34 busy cycles without done
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= MAXC; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (i == MAXC - 1) chk("to_still_busy", 32'(ctrl_state), 32'd1);
    end
    chk("to_state_run", 32'(ctrl_state), 32'd0);
    chk("to_err_set", 32'(mdu_err), 32'd1);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("to_err_sticky", 32'(mdu_err), 32'd1);
    cycle(1, 0, 0, 0, 0, 0);
    chk("to_err_cleared", 32'(mdu_err), 32'd0);

    // Memory wait mid-MDU at counter 5: count holds, timeout still after 34 busy cycles
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      check_model();
      chk("dw_mdu_enables", 32'(dut_out()), 32'(O_HALT));
      finish_cycle();
      chk("dw_mdu_busy", 32'(ctrl_state), 32'd1);
    end
    for (int i = 0; i < MAXC - 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (i == MAXC - 6) chk("dw_resume_busy", 32'(ctrl_state), 32'd1);
    end
    chk("dw_timeout_run", 32'(ctrl_state), 32'd0);
    chk("dw_timeout_err", 32'(mdu_err), 32'd1);

    // Reset mid-MDU
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_mid_state", 32'(ctrl_state), 32'd0);
    chk("rst_mid_err", 32'(mdu_err), 32'd0);
    chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);

    // Stall counter saturation
    for (int i = 0; i < SMAX + 5; i++) cycle(0, 0, 0, 0, 0, 1);
    chk("sat_cnt", 32'(stall_cnt), 32'(SMAX));
    cycle(0, 1, 0, 0, 0, 0);
    chk("sat_hold", 32'(stall_cnt), 32'(SMAX));
    cycle(1, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
